// File: rtl/add_arb2_if.sv
// Request/grant and response bundle for the two-requester shared adder.
// The master side drives requests; the slave side is the arbiter.
interface add_arb2_if #(
  parameter int W = 128
);
  logic         req0;
  logic         chain0;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic         cin0;
  logic         gnt0;

  logic         req1;
  logic         chain1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         cin1;
  logic         gnt1;

  logic         rsp_valid;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;

  modport master (
    output req0, chain0, a0, b0, cin0,
    output req1, chain1, a1, b1, cin1,
    input  gnt0, gnt1,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req0, chain0, a0, b0, cin0,
    input  req1, chain1, a1, b1, cin1,
    output gnt0, gnt1,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/add_arb2.sv
// Round-robin arbiter feeding one shared ripple adder through a
// 2-stage pipeline, with a stored carry per requester for chaining.
module add_arb2 #(
  parameter int W = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  add_arb2_if.slave  bus
);

  localparam int NS = W / 16;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         chain;
    logic         id;
  } s1_t;

  function automatic logic [16:0] rca16(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        ci
  );
    logic [15:0] s;
    logic        c;
    c = ci;
    for (int i = 0; i < 16; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, s};
  endfunction

  logic         ptr_q, ptr_d;
  logic [1:0]   carry_q, carry_d;
  logic         s1_valid_q, s1_valid_d;
  s1_t          s1_q, s1_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_sum_q, rsp_sum_d;
  logic         rsp_cout_q, rsp_cout_d;

  logic         g0, g1, acc, cin_eff;
  logic [W-1:0] sum;
  logic         cout, cy;
  logic [16:0]  sl;

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        (bus.req0 & ~bus.req1): g0 = 1'b1;
        (bus.req1 & ~bus.req0): g1 = 1'b1;
        (bus.req0 & bus.req1): begin
          g0 = ~ptr_q;
          g1 = ptr_q;
        end
        default: ;
      endcase
    end
  end

  assign acc      = g0 | g1;
  assign bus.gnt0 = g0;
  assign bus.gnt1 = g1;

  assign cin_eff = s1_q.chain ? carry_q[s1_q.id] : s1_q.cin;

  // Ripple of 16-bit slices, carry threaded slice to slice
  always_comb begin
    sum = '0;
    sl  = '0;
    cy  = cin_eff;
    for (int k = 0; k < NS; k++) begin
      sl = rca16(s1_q.a[k*16 +: 16], s1_q.b[k*16 +: 16], cy);
      sum[k*16 +: 16] = sl[15:0];
      cy = sl[16];
    end
    cout = cy;
  end

  always_comb begin
    ptr_d       = ptr_q;
    s1_valid_d  = acc;
    s1_d        = s1_q;
    carry_d     = carry_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    if (acc) begin
      ptr_d = ~g1;
      if (g1) begin
        s1_d = '{a: bus.a1, b: bus.b1, cin: bus.cin1,
                 chain: bus.chain1, id: 1'b1};
      end else begin
        s1_d = '{a: bus.a0, b: bus.b0, cin: bus.cin0,
                 chain: bus.chain0, id: 1'b0};
      end
    end
    if (s1_valid_q) begin
      rsp_valid_d         = 1'b1;
      rsp_id_d            = s1_q.id;
      rsp_sum_d           = sum;
      rsp_cout_d          = cout;
      carry_d[s1_q.id]    = cout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= 1'b0;
      carry_q     <= '0;
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      carry_q     <= carry_d;
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_add_arb2.sv
// Directed bench for add_arb2: reset, round-robin grants, chaining,
// carry isolation and mid-operation reset.
module tb_add_arb2;

  localparam int W = 128;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [W-1:0] ones;

  add_arb2_if #(.W(W)) bus ();

  add_arb2 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [W-1:0] got,
    input logic [W-1:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(
    input string        tag,
    input logic         id,
    input logic [W-1:0] s,
    input logic         co
  );
    check({tag, ".v"}, W'(bus.rsp_valid), W'(1));
    check({tag, ".id"}, W'(bus.rsp_id), W'(id));
    check({tag, ".sum"}, bus.rsp_sum, s);
    check({tag, ".co"}, W'(bus.rsp_cout), W'(co));
  endtask

  task automatic gnts(
    input string tag,
    input logic  e0,
    input logic  e1
  );
    #1;
    check({tag, ".g0"}, W'(bus.gnt0), W'(e0));
    check({tag, ".g1"}, W'(bus.gnt1), W'(e1));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ones  = '1;
    rst_n = 1'b0;
    bus.req0 = 1'b1; bus.chain0 = 1'b0; bus.cin0 = 1'b0;
    bus.a0 = W'(25); bus.b0 = W'(25);
    bus.req1 = 1'b1; bus.chain1 = 1'b0; bus.cin1 = 1'b0;
    bus.a1 = W'(240); bus.b1 = W'(1232);

    for (int i = 0; i < 3; i++) begin
      step();
      gnts("rst", 1'b0, 1'b0);
      check("rst.v", W'(bus.rsp_valid), W'(0));
    end
    check("rst.sum", bus.rsp_sum, W'(0));
    check("rst.co", W'(bus.rsp_cout), W'(0));

    rst_n = 1'b1;
    gnts("rr0", 1'b1, 1'b0);
    step();
    gnts("rr1", 1'b0, 1'b1);
    check("rr1.v", W'(bus.rsp_valid), W'(0));
    step();
    gnts("rr2", 1'b1, 1'b0);
    rsp("rr2", 1'b0, W'(50), 1'b0);
    step();
    gnts("rr3", 1'b0, 1'b1);
    rsp("rr3", 1'b1, W'(1472), 1'b0);
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    gnts("idle", 1'b0, 1'b0);
    rsp("rr4", 1'b0, W'(50), 1'b0);
    step();
    rsp("rr5", 1'b1, W'(1472), 1'b0);
    step();
    check("rr6.v", W'(bus.rsp_valid), W'(0));
    check("rr6.hold", bus.rsp_sum, W'(1472));

    bus.req1 = 1'b1; bus.a1 = ones; bus.b1 = W'(1);
    bus.chain1 = 1'b0; bus.cin1 = 1'b0;
    gnts("ch0", 1'b0, 1'b1);
    step();
    bus.a1 = '0; bus.b1 = '0; bus.chain1 = 1'b1;
    gnts("ch1", 1'b0, 1'b1);
    step();
    bus.req1 = 1'b0;
    rsp("ch.w1", 1'b1, W'(0), 1'b1);
    step();
    rsp("ch.w2", 1'b1, W'(1), 1'b0);
    step();
    check("ch.end", W'(bus.rsp_valid), W'(0));

    bus.req0 = 1'b1; bus.a0 = ones; bus.b0 = W'(1); bus.chain0 = 1'b0;
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = W'(5); bus.b1 = W'(5); bus.chain1 = 1'b1;
    step();
    bus.req1 = 1'b0;
    rsp("iso.c0", 1'b0, W'(0), 1'b1);
    bus.req0 = 1'b1; bus.a0 = W'(3); bus.b0 = W'(4); bus.chain0 = 1'b1;
    step();
    bus.req0 = 1'b0;
    rsp("iso.r1", 1'b1, W'(10), 1'b0);
    step();
    rsp("iso.r0", 1'b0, W'(8), 1'b0);

    bus.req0 = 1'b1; bus.a0 = ones; bus.b0 = W'(1); bus.chain0 = 1'b0;
    step();
    bus.req0 = 1'b0;
    step();
    rsp("mr.set", 1'b0, W'(0), 1'b1);
    bus.req0 = 1'b1; bus.a0 = W'(7); bus.b0 = W'(7); bus.chain0 = 1'b0;
    step();
    bus.req0 = 1'b0;
    rst_n = 1'b0;
    step();
    check("mr.v0", W'(bus.rsp_valid), W'(0));
    rst_n = 1'b1;
    step();
    check("mr.v1", W'(bus.rsp_valid), W'(0));
    step();
    check("mr.v2", W'(bus.rsp_valid), W'(0));
    bus.req0 = 1'b1; bus.a0 = W'(1); bus.b0 = W'(1); bus.chain0 = 1'b1;
    gnts("mr.g", 1'b1, 1'b0);
    step();
    bus.req0 = 1'b0;
    step();
    rsp("mr.ch", 1'b0, W'(2), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
